pattern_loader: RTL

Reads one 30-rectangle pattern out of the pattern ROM on request and serves per-pixel rectangle hit tests to the VGA pixel pipeline. It drives the ROM's `p_oe`/`p_Addr` read port and consumes `p_Data`, which is registered in the ROM with one-cycle read latency. Rectangles land in a shadow bank and are committed atomically to an active bank, so a frame never shows a partially loaded pattern. It sits between the frame timing logic (`start` at frame start) and the pixel colour mux (`in_rect`, `rect_idx`).

---
 rtl/pattern_loader_if.sv | 10 +
 rtl/pattern_loader.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/pattern_loader_if.sv
// Read port between the pattern loader and the pattern ROM.
// The ROM registers p_Data, so each word arrives one cycle after p_oe/p_Addr.
interface pattern_loader_if;
   logic        p_oe;
   logic [7:0]  p_Addr;
   logic [37:0] p_Data;

   modport master (output p_oe, output p_Addr, input p_Data);
   modport slave  (input p_oe, input p_Addr, output p_Data);
endinterface

// File: rtl/pattern_loader.sv
// Loads one 30-rectangle pattern from the ROM into a shadow bank and commits it to the active bank in one cycle.
// The active bank feeds a registered per-pixel hit test with lowest-index priority.
module pattern_loader #(
   parameter int N_RECT = 30,
   parameter int N_PAT  = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       i_start,
   input  logic [$clog2(N_PAT)-1:0]   i_pattern_sel,
   pattern_loader_if.master           rom,
   output logic                       o_busy,
   output logic                       o_done,
   output logic [$clog2(N_PAT)-1:0]   o_loaded_pattern,
   input  logic [9:0]                 i_x_pixel,
   input  logic [8:0]                 i_y_pixel,
   output logic                       o_in_rect,
   output logic [4:0]                 o_rect_idx
);

   localparam int          SEL_W    = $clog2(N_PAT);
   localparam logic [37:0] DISABLED = {10'h3FF, 9'd0, 10'd0, 9'd0};
   localparam logic [4:0]  LAST_IDX = 5'(N_RECT - 1);
   localparam logic [4:0]  NO_HIT   = 5'd31;

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN, COMMIT} loaderState_t;

   loaderState_t r_state;
   loaderState_t w_stateNext;

   logic             r_oe;
   logic [7:0]       r_addr;
   logic [4:0]       r_i;
   logic [7:0]       r_base;
   logic [SEL_W-1:0] r_sel;
   logic [SEL_W-1:0] r_loaded;
   logic             r_done;
   logic             r_capV;
   logic [4:0]       r_capIdx;
   logic [37:0]      r_shadow [N_RECT];
   logic [37:0]      r_active [N_RECT];
   logic             r_inRect;
   logic [4:0]       r_rectIdx;

   logic             w_oeNext;
   logic [7:0]       w_addrNext;
   logic [4:0]       w_iNext;
   logic [4:0]       w_iInc;
   logic [7:0]       w_baseNext;
   logic [7:0]       w_startBase;
   logic [SEL_W-1:0] w_selNext;
   logic             w_commit;
   logic [N_RECT-1:0] w_hit;
   logic [4:0]       w_hitIdx;

   assign w_startBase = 8'(i_pattern_sel) * 8'(N_RECT);
   assign w_iInc      = r_i + 5'd1;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_stateNext;
      end
   end

   always_comb begin
      w_stateNext = r_state;
      w_oeNext    = 1'b0;
      w_addrNext  = r_addr;
      w_iNext     = r_i;
      w_baseNext  = r_base;
      w_selNext   = r_sel;
      w_commit    = 1'b0;
      case (r_state)
         IDLE: begin
            if (i_start) begin
               w_stateNext = FETCH;
               w_oeNext    = 1'b1;
               w_baseNext  = w_startBase;
               w_addrNext  = w_startBase;
               w_iNext     = 5'd0;
               w_selNext   = i_pattern_sel;
            end
         end
         FETCH: begin
            if (r_i == LAST_IDX) begin
               w_stateNext = DRAIN;
            end else begin
               w_oeNext   = 1'b1;
               w_iNext    = w_iInc;
               w_addrNext = r_base + {3'd0, w_iInc};
            end
         end
         DRAIN: begin
            w_stateNext = COMMIT;
         end
         COMMIT: begin
            w_commit    = 1'b1;
            w_stateNext = IDLE;
         end
         default: begin
            w_stateNext = IDLE;
         end
      endcase
   end

   // The capture pipeline lags the read port by one cycle to match the ROM's registered output.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_oe     <= 1'b0;
         r_addr   <= 8'd0;
         r_i      <= 5'd0;
         r_base   <= 8'd0;
         r_sel    <= '0;
         r_loaded <= '0;
         r_done   <= 1'b0;
         r_capV   <= 1'b0;
         r_capIdx <= 5'd0;
         for (int e = 0; e < N_RECT; e++) begin
            r_shadow[e] <= DISABLED;
            r_active[e] <= DISABLED;
         end
      end else begin
         r_oe     <= w_oeNext;
         r_addr   <= w_addrNext;
         r_i      <= w_iNext;
         r_base   <= w_baseNext;
         r_sel    <= w_selNext;
         r_done   <= w_commit;
         r_capV   <= r_oe;
         r_capIdx <= r_i;
         if (r_capV) begin
            r_shadow[r_capIdx] <= rom.p_Data;
         end
         if (w_commit) begin
            r_active <= r_shadow;
            r_loaded <= r_sel;
         end
      end
   end

   // A disabled entry has x0 > x1 or y0 > y1, so the inclusive bounds test alone rejects it.
   always_comb begin
      w_hit    = '0;
      w_hitIdx = NO_HIT;
      for (int e = 0; e < N_RECT; e++) begin
         w_hit[e] = (i_x_pixel >= r_active[e][37:28]) && (i_x_pixel <= r_active[e][18:9]) &&
                    (i_y_pixel >= r_active[e][27:19]) && (i_y_pixel <= r_active[e][8:0]);
      end
      for (int e = N_RECT - 1; e >= 0; e--) begin
         if (w_hit[e]) begin
            w_hitIdx = 5'(e);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_inRect  <= 1'b0;
         r_rectIdx <= NO_HIT;
      end else begin
         r_inRect  <= |w_hit;
         r_rectIdx <= w_hitIdx;
      end
   end

   assign rom.p_oe        = r_oe;
   assign rom.p_Addr      = r_addr;
   assign o_busy           = (r_state != IDLE);
   assign o_done           = r_done;
   assign o_loaded_pattern = r_loaded;
   assign o_in_rect        = r_inRect;
   assign o_rect_idx       = r_rectIdx;

endmodule
